// File: rtl/duty_update_arbiter.sv
// Round-robin arbiter that applies signed left/right duty corrections through one
// shared saturating adder using a three-state IDLE -> CALC -> COMMIT pipeline.
module duty_update_arbiter #(
    parameter int          WIDTH     = 8,
    parameter int unsigned INIT_DUTY = 2 ** (WIDTH - 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    freeze,
    input  logic                    req_l_valid,
    input  logic signed [WIDTH:0]   req_l_delta,
    output logic                    req_l_ready,
    input  logic                    req_r_valid,
    input  logic signed [WIDTH:0]   req_r_delta,
    output logic                    req_r_ready,
    output logic [WIDTH-1:0]        duty_l,
    output logic [WIDTH-1:0]        duty_r,
    output logic                    upd_valid,
    output logic                    upd_side,
    output logic                    sat_flag
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CALC   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    localparam logic signed [WIDTH+1:0] DUTY_MAX = $signed({2'b00, {WIDTH{1'b1}}});

    // Returns {saturated, clamp(duty + delta, 0, 2**WIDTH-1)}.
    function automatic logic [WIDTH:0] sat_add(input logic [WIDTH-1:0]   duty,
                                               input logic signed [WIDTH:0] delta);
        logic signed [WIDTH+1:0] sum;
        sum = $signed({2'b00, duty}) + $signed({delta[WIDTH], delta});
        if (sum[WIDTH+1]) begin
            sat_add = {1'b1, {WIDTH{1'b0}}};
        end else if (sum > DUTY_MAX) begin
            sat_add = {1'b1, {WIDTH{1'b1}}};
        end else begin
            sat_add = {1'b0, sum[WIDTH-1:0]};
        end
    endfunction

    state_t                  state_r;
    logic                    last_served_r;
    logic                    side_r;
    logic signed [WIDTH:0]   delta_r;
    logic [WIDTH-1:0]        duty_cur_r;
    logic [WIDTH-1:0]        result_r;
    logic                    sat_r;
    logic                    accept_ok_s;

    // Ready generation: only the granted side sees ready, and only in IDLE.
    always_comb begin
        accept_ok_s = (state_r == ST_IDLE) && !freeze && !reset;
        req_l_ready = 1'b0;
        req_r_ready = 1'b0;
        if (accept_ok_s) begin
            // On a tie, the side not served last wins.
            req_l_ready = req_l_valid && (!req_r_valid || last_served_r);
            req_r_ready = req_r_valid && (!req_l_valid || !last_served_r);
        end else begin
            req_l_ready = 1'b0;
            req_r_ready = 1'b0;
        end
    end

    // Update FSM with all registered state and outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            last_served_r <= 1'b1;
            side_r        <= 1'b0;
            delta_r       <= {(WIDTH+1){1'b0}};
            duty_cur_r    <= {WIDTH{1'b0}};
            result_r      <= {WIDTH{1'b0}};
            sat_r         <= 1'b0;
            duty_l        <= WIDTH'(INIT_DUTY);
            duty_r        <= WIDTH'(INIT_DUTY);
            upd_valid     <= 1'b0;
            upd_side      <= 1'b0;
            sat_flag      <= 1'b0;
        end else begin
            upd_valid <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (req_l_valid && req_l_ready) begin
                        side_r        <= 1'b0;
                        delta_r       <= req_l_delta;
                        duty_cur_r    <= duty_l;
                        last_served_r <= 1'b0;
                        state_r       <= ST_CALC;
                    end else if (req_r_valid && req_r_ready) begin
                        side_r        <= 1'b1;
                        delta_r       <= req_r_delta;
                        duty_cur_r    <= duty_r;
                        last_served_r <= 1'b1;
                        state_r       <= ST_CALC;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    {sat_r, result_r} <= sat_add(duty_cur_r, delta_r);
                    state_r           <= ST_COMMIT;
                end
                ST_COMMIT: begin
                    if (side_r) begin
                        duty_r <= result_r;
                    end else begin
                        duty_l <= result_r;
                    end
                    upd_side  <= side_r;
                    sat_flag  <= sat_r;
                    upd_valid <= 1'b1;
                    state_r   <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_duty_update_arbiter.sv
// Self-checking bench for duty_update_arbiter: directed scenarios plus a randomized
// run against a cycle-count reference model of arbitration and saturation.
module tb_duty_update_arbiter;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              freeze = 1'b0;
    logic              req_l_valid = 1'b0;
    logic signed [8:0] req_l_delta = 9'sd0;
    logic              req_l_ready;
    logic              req_r_valid = 1'b0;
    logic signed [8:0] req_r_delta = 9'sd0;
    logic              req_r_ready;
    logic [7:0]        duty_l;
    logic [7:0]        duty_r;
    logic              upd_valid;
    logic              upd_side;
    logic              sat_flag;

    int n_vec = 0;
    int n_err = 0;

    duty_update_arbiter #(.WIDTH(8), .INIT_DUTY(128)) dut (
        .clk(clk), .reset(reset), .freeze(freeze),
        .req_l_valid(req_l_valid), .req_l_delta(req_l_delta), .req_l_ready(req_l_ready),
        .req_r_valid(req_r_valid), .req_r_delta(req_r_delta), .req_r_ready(req_r_ready),
        .duty_l(duty_l), .duty_r(duty_r),
        .upd_valid(upd_valid), .upd_side(upd_side), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic apply_reset();
        reset = 1'b1; freeze = 1'b0; req_l_valid = 1'b0; req_r_valid = 1'b0;
        cyc(); cyc();
        reset = 1'b0;
    endtask

    // Issue one request on a side and wait (bounded) for its upd_valid pulse.
    task automatic issue(input logic side, input logic signed [8:0] d);
        int n;
        if (side) begin req_r_valid = 1'b1; req_r_delta = d; end
        else      begin req_l_valid = 1'b1; req_l_delta = d; end
        #1;
        n = 0;
        while (!(side ? req_r_ready : req_l_ready) && n < 10) begin cyc(); n++; end
        cyc();
        req_l_valid = 1'b0; req_r_valid = 1'b0;
        while (!upd_valid && n < 20) begin cyc(); n++; end
        n_vec++;
        if (n >= 10) begin
            n_err++;
            $display("FAIL issue_timeout: waited %0d cycles, required < 10", n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; req_l_valid = 1'b1; req_r_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cyc(); #1;
            n_vec++;
            if ({req_l_ready, req_r_ready} !== 2'b00) begin
                n_err++; $display("FAIL reset_ready: got %b required 00", {req_l_ready, req_r_ready});
            end
        end
        reset = 1'b0; req_l_valid = 1'b0; req_r_valid = 1'b0;
        n_vec++;
        if ({duty_l, duty_r, upd_valid, upd_side, sat_flag} !== {8'd128, 8'd128, 3'b000}) begin
            n_err++;
            $display("FAIL reset_state: duty_l=%0d duty_r=%0d uv=%b us=%b sat=%b required 128 128 0 0 0",
                     duty_l, duty_r, upd_valid, upd_side, sat_flag);
        end
    endtask

    task automatic test_single();
        apply_reset();
        req_l_valid = 1'b1; req_l_delta = 9'sd50; #1;
        n_vec++;
        if (req_l_ready !== 1'b1) begin n_err++; $display("FAIL single_ready: got %b required 1", req_l_ready); end
        cyc(); req_l_valid = 1'b0;
        cyc();
        n_vec++;
        if (duty_l !== 8'd128 || upd_valid !== 1'b0) begin
            n_err++; $display("FAIL single_early: duty_l=%0d uv=%b required 128 0", duty_l, upd_valid);
        end
        cyc();
        n_vec++;
        if ({duty_l, duty_r, upd_valid, upd_side, sat_flag} !== {8'd178, 8'd128, 3'b100}) begin
            n_err++;
            $display("FAIL single_commit: duty_l=%0d duty_r=%0d uv=%b us=%b sat=%b required 178 128 1 0 0",
                     duty_l, duty_r, upd_valid, upd_side, sat_flag);
        end
        cyc();
        n_vec++;
        if (upd_valid !== 1'b0) begin n_err++; $display("FAIL single_pulse: uv=%b required 0", upd_valid); end
    endtask

    task automatic test_saturation();
        apply_reset();
        issue(1'b1, -9'sd200);
        n_vec++;
        if ({duty_r, sat_flag, upd_side} !== {8'd0, 2'b11}) begin
            n_err++; $display("FAIL sat_r_low: duty_r=%0d sat=%b us=%b required 0 1 1", duty_r, sat_flag, upd_side);
        end
        issue(1'b1, 9'sd255);
        n_vec++;
        if ({duty_r, sat_flag} !== {8'd255, 1'b0}) begin
            n_err++; $display("FAIL sat_r_exact: duty_r=%0d sat=%b required 255 0", duty_r, sat_flag);
        end
        issue(1'b0, 9'sd255);
        n_vec++;
        if ({duty_l, sat_flag, upd_side} !== {8'd255, 2'b10}) begin
            n_err++; $display("FAIL sat_l_high: duty_l=%0d sat=%b us=%b required 255 1 0", duty_l, sat_flag, upd_side);
        end
        issue(1'b0, -9'sd256);
        n_vec++;
        if ({duty_l, sat_flag, duty_r} !== {8'd0, 1'b1, 8'd255}) begin
            n_err++; $display("FAIL sat_l_min: duty_l=%0d sat=%b duty_r=%0d required 0 1 255", duty_l, sat_flag, duty_r);
        end
        issue(1'b0, 9'sd0);
        n_vec++;
        if ({duty_l, sat_flag} !== {8'd0, 1'b0}) begin
            n_err++; $display("FAIL zero_delta: duty_l=%0d sat=%b required 0 0", duty_l, sat_flag);
        end
    endtask

    task automatic test_tie();
        apply_reset();
        req_l_valid = 1'b1; req_l_delta = 9'sd10;
        req_r_valid = 1'b1; req_r_delta = -9'sd10;
        #1;
        n_vec++;
        if ({req_l_ready, req_r_ready} !== 2'b10) begin
            n_err++; $display("FAIL tie_grant: got %b required 10", {req_l_ready, req_r_ready});
        end
        cyc(); req_l_valid = 1'b0; #1;
        for (int i = 0; i < 2; i++) begin
            n_vec++;
            if (req_r_ready !== 1'b0 || upd_valid !== 1'b0) begin
                n_err++; $display("FAIL tie_wait: r_ready=%b uv=%b required 0 0", req_r_ready, upd_valid);
            end
            cyc(); #1;
        end
        n_vec++;
        if (req_r_ready !== 1'b1 || upd_valid !== 1'b1) begin
            n_err++; $display("FAIL tie_second: r_ready=%b uv=%b required 1 1", req_r_ready, upd_valid);
        end
        cyc(); req_r_valid = 1'b0;
        cyc(); cyc();
        n_vec++;
        if ({duty_l, duty_r, upd_valid, upd_side} !== {8'd138, 8'd118, 2'b11}) begin
            n_err++; $display("FAIL tie_final: duty_l=%0d duty_r=%0d uv=%b us=%b required 138 118 1 1",
                              duty_l, duty_r, upd_valid, upd_side);
        end
    endtask

    task automatic test_reset_abort();
        int pulses;
        apply_reset();
        req_l_valid = 1'b1; req_l_delta = 9'sd50;
        cyc(); req_l_valid = 1'b0; reset = 1'b1;
        cyc(); reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            if (upd_valid) pulses++;
            cyc();
        end
        n_vec++;
        if (duty_l !== 8'd128 || pulses != 0) begin
            n_err++; $display("FAIL abort: duty_l=%0d pulses=%0d required 128 0", duty_l, pulses);
        end
        req_l_valid = 1'b1; req_l_delta = 9'sd1; #1;
        n_vec++;
        if (req_l_ready !== 1'b1) begin n_err++; $display("FAIL abort_idle: l_ready=%b required 1", req_l_ready); end
        req_l_valid = 1'b0;
    endtask

    task automatic test_freeze();
        apply_reset();
        freeze = 1'b1; req_l_valid = 1'b1; req_l_delta = -9'sd28;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_vec++;
            if (req_l_ready !== 1'b0 || duty_l !== 8'd128 || duty_r !== 8'd128) begin
                n_err++; $display("FAIL freeze_hold: l_ready=%b duty_l=%0d duty_r=%0d required 0 128 128",
                                  req_l_ready, duty_l, duty_r);
            end
            cyc();
        end
        freeze = 1'b0; #1;
        n_vec++;
        if (req_l_ready !== 1'b1) begin n_err++; $display("FAIL freeze_release: l_ready=%b required 1", req_l_ready); end
        cyc(); req_l_valid = 1'b0; freeze = 1'b1;
        cyc(); cyc();
        n_vec++;
        if ({duty_l, upd_valid, sat_flag} !== {8'd100, 2'b10}) begin
            n_err++; $display("FAIL freeze_inflight: duty_l=%0d uv=%b sat=%b required 100 1 0", duty_l, upd_valid, sat_flag);
        end
        freeze = 1'b0;
    endtask

    function automatic logic signed [8:0] rnd_delta();
        logic signed [8:0] d;
        case ($urandom_range(0, 4))
            0: d = 9'sd0;
            1: d = 9'h100;
            2: d = 9'sd255;
            default: d = 9'($urandom_range(0, 511));
        endcase
        return d;
    endfunction

    task automatic test_random();
        int  m_duty[2];
        int  m_busy, p_val, sum;
        bit  m_last, p_side, p_sat, m_uv, m_us, m_sat;
        bit  hold_l, hold_r, exp_rl, exp_rr, idle;
        apply_reset();
        m_duty[0] = 128; m_duty[1] = 128; m_busy = 0; m_last = 1'b1;
        m_uv = 1'b0; m_us = 1'b0; m_sat = 1'b0; hold_l = 1'b0; hold_r = 1'b0;
        p_val = 0; p_side = 1'b0; p_sat = 1'b0;
        for (int c = 0; c < 600; c++) begin
            reset  = ($urandom_range(0, 99) < 2);
            freeze = ($urandom_range(0, 99) < 20);
            if (hold_l && $urandom_range(0, 9) != 0) req_l_valid = 1'b1;
            else begin req_l_valid = $urandom_range(0, 1); req_l_delta = rnd_delta(); end
            if (hold_r && $urandom_range(0, 9) != 0) req_r_valid = 1'b1;
            else begin req_r_valid = $urandom_range(0, 1); req_r_delta = rnd_delta(); end
            #1;
            idle   = (m_busy == 0) && !freeze && !reset;
            exp_rl = idle && req_l_valid && (!req_r_valid || m_last);
            exp_rr = idle && req_r_valid && (!req_l_valid || !m_last);
            n_vec++;
            if ({req_l_ready, req_r_ready} !== {exp_rl, exp_rr}) begin
                n_err++; $display("FAIL rnd_ready c=%0d: got %b required %b", c, {req_l_ready, req_r_ready}, {exp_rl, exp_rr});
            end
            hold_l = req_l_valid && !exp_rl;
            hold_r = req_r_valid && !exp_rr;
            if (reset) begin
                m_duty[0] = 128; m_duty[1] = 128; m_busy = 0; m_last = 1'b1;
                m_uv = 1'b0; m_us = 1'b0; m_sat = 1'b0;
            end else begin
                m_uv = 1'b0;
                if (m_busy > 0) begin
                    m_busy--;
                    if (m_busy == 0) begin
                        m_duty[p_side] = p_val; m_uv = 1'b1; m_us = p_side; m_sat = p_sat;
                    end
                end
                if (exp_rl || exp_rr) begin
                    p_side = exp_rr;
                    sum = m_duty[p_side] + int'(exp_rr ? req_r_delta : req_l_delta);
                    p_sat = (sum < 0) || (sum > 255);
                    p_val = (sum < 0) ? 0 : (sum > 255) ? 255 : sum;
                    m_last = p_side;
                    m_busy = 2;
                end
            end
            cyc();
            n_vec++;
            if (duty_l !== 8'(m_duty[0]) || duty_r !== 8'(m_duty[1]) ||
                upd_valid !== m_uv || upd_side !== m_us || sat_flag !== m_sat) begin
                n_err++;
                $display("FAIL rnd_state c=%0d: got l=%0d r=%0d uv=%b us=%b sat=%b required l=%0d r=%0d uv=%b us=%b sat=%b",
                         c, duty_l, duty_r, upd_valid, upd_side, sat_flag,
                         m_duty[0], m_duty[1], m_uv, m_us, m_sat);
            end
        end
        reset = 1'b0; freeze = 1'b0; req_l_valid = 1'b0; req_r_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_saturation();
        test_tie();
        test_reset_abort();
        test_freeze();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/duty_update_arbiter.md
DUTY_UPDATE_ARBITER -- requirements
Module: duty_update_arbiter

Interface
REQ-001 Parameter WIDTH, default 8: unsigned duty width; deltas are WIDTH+1 bits signed.
REQ-002 Parameter INIT_DUTY, default 2**(WIDTH-1): duty value after reset.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 freeze  input  1  high blocks new request acceptance; an in-flight update still completes.
REQ-006 req_l_valid  input  1  left-wheel correction request.
REQ-007 req_l_delta  input  WIDTH+1 signed  left correction; stable while req_l_valid is high and not accepted.
REQ-008 req_l_ready  output  1  left request accepted this cycle when req_l_valid and req_l_ready are both high.
REQ-009 req_r_valid, req_r_delta, req_r_ready  same widths and meaning as REQ-006..008, right wheel.
REQ-010 duty_l  output  WIDTH  registered left duty value.
REQ-011 duty_r  output  WIDTH  registered right duty value.
REQ-012 upd_valid  output  1  one-cycle pulse: a duty register changed on the preceding edge.
REQ-013 upd_side  output  1  side of last update: 0 = left, 1 = right; held between updates.
REQ-014 sat_flag  output  1  last update was clamped; held between updates.

Function
REQ-015 One shared saturating add path serves both sides; at most one update is in flight.
REQ-016 FSM states: IDLE, CALC, COMMIT; transitions IDLE->CALC on acceptance, CALC->COMMIT unconditionally, COMMIT->IDLE unconditionally.
REQ-017 Readies are combinational and are high only in IDLE with freeze low; at most one ready is high per cycle.
REQ-018 Grant in IDLE: if only one side is valid, that side is granted; if both are valid, the side not in last_served is granted (round-robin).
REQ-019 Acceptance edge: latch delta, side and the current duty of that side; set last_served to that side; go to CALC.
REQ-020 CALC edge: compute sum = duty + sign-extended delta in WIDTH+2 bit signed arithmetic; register clamp(sum, 0, 2**WIDTH-1) and a saturation bit (set if sum < 0 or sum > 2**WIDTH-1).
REQ-021 COMMIT edge: write the result into the selected duty register; set upd_side, sat_flag and upd_valid=1; go to IDLE.
REQ-022 upd_valid is high exactly one cycle, coincident with the first cycle the new duty is visible; in all other cycles it is low.
REQ-023 Latency: the new duty is visible 3 rising edges after the acceptance cycle's edge is counted as edge 1; peak throughput is one update per 3 cycles.
REQ-024 A request may be accepted in the same cycle upd_valid is high, because the FSM is in IDLE.
REQ-025 The non-selected duty register never changes during an update.
REQ-026 Boundaries: delta=0 leaves duty unchanged with sat_flag=0; sum exactly 0 or exactly 2**WIDTH-1 does not set sat_flag; delta=-2**WIDTH from any duty yields 0.
REQ-027 freeze rising while in CALC or COMMIT does not cancel the update; freeze only gates readies.
REQ-028 The valid of an unaccepted request may drop without side effects; there is no queuing beyond the single in-flight slot.

Reset
REQ-029 On a reset edge: state=IDLE, duty_l=duty_r=INIT_DUTY, upd_valid=0, upd_side=0, sat_flag=0, last_served=right (left wins the first tie).
REQ-030 While reset is high, both readies are 0.
REQ-031 Reset during CALC or COMMIT aborts the update: no duty write and no upd_valid pulse.

Verification (WIDTH=8, INIT_DUTY=128)
REQ-032 After reset, left delta=+50 -> accepted at once; 3 edges later duty_l=178, upd_valid=1 for 1 cycle, upd_side=0, sat_flag=0, duty_r=128.
REQ-033 Right delta=-200 from 128 -> duty_r=0, sat_flag=1, upd_side=1; then right delta=+255 -> duty_r=255, sat_flag=0 (exact max, not clamped).
REQ-034 Left delta=+255 from 128 -> duty_l=255, sat_flag=1; then left delta=-256 -> duty_l=0, sat_flag=1.
REQ-035 After reset, both sides valid in the same cycle (left +10, right -10) -> left accepted first, req_r_ready=0 until the upd_valid cycle; right then accepted; final duty_l=138, duty_r=118.
REQ-036 Left update accepted, reset asserted in the CALC cycle -> duty_l=128, no upd_valid pulse; FSM in IDLE after reset is released.
REQ-037 freeze=1 with req_l_valid=1 for 5 cycles -> req_l_ready stays 0 and duties are unchanged; freeze=0 -> accepted in that cycle and completes normally.
